// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered priority pointer and stall
//
// Purpose:
//   Grants at most one of CLIENTS requesters per cycle. The grant is a pure
//   combinational function of the current request vector and a registered
//   priority pointer. After each accepted grant the pointer moves to the client
//   just past the winner, so a persistent requester waits at most CLIENTS-1
//   non-stalled cycles.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset; forces grant to zero, ptr to 0
//   request  in   [CLIENTS-1:0] bit i high = client i requests
//   stall    in   high = hold the pointer this cycle
//   grant    out  [CLIENTS-1:0] one-hot or zero grant

module rr_arbiter #(
    parameter int CLIENTS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLIENTS-1:0] request,
    input  logic               stall,
    output logic [CLIENTS-1:0] grant
);

    localparam int PTR_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(CLIENTS - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] idx_hi;
    logic [PTR_W-1:0] idx_any;
    logic [PTR_W-1:0] sel;
    logic             found_hi;
    logic             any_req;

    // Two find-first encoders: one restricted to clients at or above ptr,
    // one over all clients. If nothing is pending at or above ptr, the search
    // has wrapped and the lowest-index requester overall wins.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_any  = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (request[i]) begin
                idx_any = PTR_W'(i);
                if (PTR_W'(i) >= ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = PTR_W'(i);
                end
            end
        end
    end

    assign any_req = |request;
    assign sel     = found_hi ? idx_hi : idx_any;

    // The reset term keeps grant low for the whole time reset is held,
    // not just until the next clock edge.
    always_comb begin
        grant = '0;
        if (reset && any_req) begin
            grant = {{(CLIENTS-1){1'b0}}, 1'b1} << sel;
        end
    end

    // Explicit wrap compare so a non-power-of-two CLIENTS never yields
    // ptr >= CLIENTS.
    always_comb begin
        ptr_next = ptr;
        if (!stall && any_req) begin
            ptr_next = (sel == LAST_IDX) ? '0 : sel + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking scoreboard bench for rr_arbiter

module tb_rr_arbiter;

    localparam int N = 32;

    logic         clock;
    logic         reset;
    logic [N-1:0] request;
    logic         stall;
    logic [N-1:0] grant;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_q[$];
    int           mptr;
    logic [N-1:0] last_grant;

    rr_arbiter #(.CLIENTS(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .stall   (stall),
        .grant   (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic [N-1:0] req, input logic stl, input string tag);
        int g;
        logic [N-1:0] e;
        logic [N-1:0] obs;
        request = req;
        stall   = stl;
        g = model_pick(req, mptr);
        e = (g < 0) ? '0 : (N'(1) << g);
        exp_q.push_back(e);
        @(negedge clock);
        obs = grant;
        check(tag, obs, exp_q.pop_front());
        check({tag, "_onehot0"}, N'($onehot0(obs)), N'(1));
        check({tag, "_subset"}, obs & ~req, '0);
        last_grant = obs;
        @(posedge clock);
        if (!stl && g >= 0) mptr = (g + 1) % N;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset   = 1'b0;
        request = '1;
        stall   = 1'b0;
        #1;
        check("reset_grant_async", grant, '0);
        @(posedge clock);
        @(negedge clock);
        check("reset_grant_held", grant, '0);
        mptr = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int wait_cnt;
        int hits[N];
        logic [N-1:0] save;

        reset   = 1'b0;
        request = '0;
        stall   = 1'b0;
        mptr    = 0;

        // Reset, then full rotation under all-ones request
        do_reset();
        for (int i = 0; i <= N; i++) begin
            step('1, 1'b0, "rotate");
            check("rotate_const", last_grant, N'(1) << (i % N));
        end

        // Single requester, then wrap search from ptr=5
        do_reset();
        step(32'h10, 1'b0, "single");
        check("single_const", last_grant, 32'h10);
        step(32'h1, 1'b0, "single_wrap");
        check("single_wrap_const", last_grant, 32'h1);

        // Fairness: wait for client 4, then it must return after exactly 31 cycles
        do_reset();
        wait_cnt = 0;
        do begin
            step('1, 1'b0, "fair_seek");
            wait_cnt++;
        end while (last_grant != 32'h10 && wait_cnt < 64);
        check("fair_seek_found", last_grant, 32'h10);
        foreach (hits[i]) hits[i] = 0;
        wait_cnt = 0;
        do begin
            step('1, 1'b0, "fair_win");
            wait_cnt++;
            for (int i = 0; i < N; i++) if (last_grant[i]) hits[i]++;
        end while (!last_grant[4] && wait_cnt < 64);
        check("fair_latency", N'(wait_cnt), N'(32));
        for (int i = 0; i < N; i++) check("fair_once", N'(hits[i]), N'(1));

        // Stall: grant frozen at 0x08, then advances to 0x10
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(32'h18, 1'b1, "stall");
            check("stall_const", last_grant, 32'h08);
        end
        step(32'h18, 1'b0, "stall_release");
        check("stall_release_const", last_grant, 32'h08);
        step(32'h18, 1'b0, "stall_resume");
        check("stall_resume_const", last_grant, 32'h10);

        // Wrap at ptr=31
        do_reset();
        step(32'h4000_0000, 1'b0, "wrap_setup");
        step(32'h8000_0001, 1'b0, "wrap_hi");
        check("wrap_hi_const", last_grant, 32'h8000_0000);
        step(32'h8000_0001, 1'b0, "wrap_lo");
        check("wrap_lo_const", last_grant, 32'h1);

        // Idle leaves the pointer alone (ptr=1 here)
        step(32'h0, 1'b0, "idle");
        check("idle_const", last_grant, 32'h0);
        step('1, 1'b0, "idle_after");
        check("idle_after_const", last_grant, 32'h2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            save = N'($urandom);
            if ($urandom_range(0, 3) == 0) save = N'(1) << $urandom_range(0, N - 1);
            if ($urandom_range(0, 7) == 0) save = '0;
            step(save, ($urandom_range(0, 3) == 0), "random");
        end

        // Mid-operation reset drops grant immediately; restart from client 0
        step('1, 1'b0, "pre_midreset");
        request = '1;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_grant", grant, '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mptr  = 0;
        step('1, 1'b0, "post_midreset");
        check("post_midreset_const", last_grant, 32'h1);

        check("queue_empty", N'(exp_q.size()), N'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
